csr_io_responder: RTL and testbench

- Peripheral end of the CSRRW GPIO path: responds to the core's CSR accesses at io0 (0xF00, switches, read) and io2 (0xF02, HEX displays, write).
- Write side: captures rs1 data when GPIO_we is asserted and drives eight active-low 7-segment digits.
- Read side: synchronizes and debounces the slide switches and presents them as io0 read data for the regsel=00 writeback path.

---
 rtl/io_pkg.sv | 43 ++++
 rtl/sw_debounce.sv | 88 ++++++++
 rtl/csr_io_responder.sv | 58 +++++
 tb/tb_csr_io_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants, debounce state encoding and the 7-segment decoder
// for the CSR GPIO responder.
package io_pkg;

  localparam logic [11:0] CSR_IO0 = 12'hF00;
  localparam logic [11:0] CSR_IO2 = 12'hF02;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DATA_W     = 32;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    DEB_IDLE  = 1'b0,
    DEB_COUNT = 1'b1
  } deb_state_e;

  // Active-low gfedcba pattern for one hex nibble
  function automatic logic [SEG_W-1:0] hex7seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop switch synchronizer followed by a counting debounce FSM; a new
// value is accepted only after it has differed from stable for DEBOUNCE_CYCLES.
module sw_debounce
  import io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic [SW_WIDTH-1:0] stable_o,
  output logic                sw_changed_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync1_q, sync2_q;
  logic [SW_WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                changed_q, changed_d;
  deb_state_e          state_q, state_d;
  logic                diff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      state_q   <= DEB_IDLE;
    end else begin
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      state_q   <= state_d;
    end
  end

  // The detecting cycle in IDLE counts as the first cycle of difference,
  // so DEBOUNCE_CYCLES=1 accepts on the edge right after sync2 differs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    diff      = (sync2_q != stable_q);
    case (state_q)
      DEB_IDLE: begin
        cnt_d = '0;
        if (diff) begin
          if (cnt_q == CNT_LAST) begin
            stable_d  = sync2_q;
            changed_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = DEB_COUNT;
          end
        end
      end
      DEB_COUNT: begin
        if (!diff) begin
          cnt_d   = '0;
          state_d = DEB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = sync2_q;
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = DEB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DEB_IDLE;
      end
    endcase
  end

  assign stable_o     = stable_q;
  assign sw_changed_o = changed_q;

endmodule

// File: rtl/csr_io_responder.sv
// Peripheral side of the CSR GPIO path: io2 write register driving eight
// 7-segment digits, and debounced switches returned as io0 read data.
module csr_io_responder
  import io_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          GPIO_we,
  input  logic [DATA_W-1:0]             gpio_wdata,
  input  logic [SW_WIDTH-1:0]           SW,
  output logic [DATA_W-1:0]             io0_rdata,
  output logic [DATA_W-1:0]             io2_q,
  output logic                          sw_changed,
  output logic [NUM_DIGITS*SEG_W-1:0]   HEX_seg
);

  logic [DATA_W-1:0]           hex_q, hex_d;
  logic [NUM_DIGITS*SEG_W-1:0] seg_q, seg_d;
  logic [SW_WIDTH-1:0]         stable;

  sw_debounce #(
    .SW_WIDTH        (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_i         (SW),
    .stable_o     (stable),
    .sw_changed_o (sw_changed)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_q <= '0;
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex_q <= hex_d;
      seg_q <= seg_d;
    end
  end

  // Write capture plus per-digit decode of the held register
  always_comb begin
    hex_d = GPIO_we ? gpio_wdata : hex_q;
    seg_d = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      seg_d[SEG_W*i +: SEG_W] = hex7seg(hex_q[4*i +: 4]);
    end
  end

  assign io2_q     = hex_q;
  assign HEX_seg   = seg_q;
  assign io0_rdata = DATA_W'(stable);

endmodule

// File: tb/tb_csr_io_responder.sv
// Scoreboard bench for csr_io_responder: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_csr_io_responder;

  localparam int unsigned SW_W = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        GPIO_we;
  logic [31:0] gpio_wdata;
  logic [SW_W-1:0] SW;
  logic [31:0] io0_rdata;
  logic [31:0] io2_q;
  logic        sw_changed;
  logic [55:0] HEX_seg;

  csr_io_responder #(.SW_WIDTH(SW_W), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .GPIO_we    (GPIO_we),
    .gpio_wdata (gpio_wdata),
    .SW         (SW),
    .io0_rdata  (io0_rdata),
    .io2_q      (io2_q),
    .sw_changed (sw_changed),
    .HEX_seg    (HEX_seg)
  );

  always #5 clk = ~clk;

  localparam int K_IO0 = 0, K_IO2 = 1, K_HEX = 2, K_CHG = 3;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        flush = 1'b0;
  logic        flushed = 1'b0;

  logic [55:0] seg_zero, seg_blank, seg_0123abcd, seg_456789ef, seg_fedcba98;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int unsigned c, input int k, input logic [63:0] v,
                           input string nm);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compare every expectation due this cycle, then drain on flush
  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_IO0:   act = 64'(io0_rdata);
          K_IO2:   act = 64'(io2_q);
          K_HEX:   act = 64'(HEX_seg);
          default: act = 64'(sw_changed);
        endcase
        n_tests++;
        if (act !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (flush && !flushed) begin
      foreach (sb[i]) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: never checked (due cyc %0d)", sb[i].name, sb[i].cyc);
      end
      sb.delete();
      flushed = 1'b1;
    end
  end

  initial begin
    int unsigned c, m;
    seg_zero     = {8{7'h40}};
    seg_blank    = {8{7'h7F}};
    seg_0123abcd = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21};
    seg_456789ef = {7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h06, 7'h0E};
    seg_fedcba98 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    rst_n = 1'b0; GPIO_we = 1'b0; gpio_wdata = '0; SW = '0;

    // Reset held for 3 edges, then released
    for (int k = 1; k <= 3; k++) expect_at(k, K_HEX, 64'(seg_blank), "hex_blank_in_reset");
    expect_at(4, K_HEX, 64'(seg_zero), "hex_zero_after_reset");
    expect_at(4, K_IO0, 64'd0, "io0_after_reset");
    expect_at(4, K_IO2, 64'd0, "io2_after_reset");
    expect_at(4, K_CHG, 64'd0, "chg_after_reset");
    step(3);
    rst_n = 1'b1;

    // Single write, then an idle cycle with junk data
    step(1);
    c = cyc;
    GPIO_we = 1'b1; gpio_wdata = 32'h0123ABCD;
    expect_at(c + 1, K_IO2, 64'h0123ABCD, "io2_write");
    expect_at(c + 1, K_HEX, 64'(seg_zero), "hex_before_decode");
    expect_at(c + 2, K_HEX, 64'(seg_0123abcd), "hex_0123abcd");
    step(1);
    GPIO_we = 1'b0; gpio_wdata = 32'hFFFFFFFF;
    expect_at(c + 2, K_IO2, 64'h0123ABCD, "io2_hold");
    expect_at(c + 3, K_IO2, 64'h0123ABCD, "io2_hold2");
    expect_at(c + 3, K_HEX, 64'(seg_0123abcd), "hex_hold");
    step(3);

    // Back-to-back writes: last one wins
    c = cyc;
    GPIO_we = 1'b1; gpio_wdata = 32'h456789EF;
    expect_at(c + 1, K_IO2, 64'h456789EF, "io2_b2b_first");
    expect_at(c + 2, K_IO2, 64'hFEDCBA98, "io2_b2b_second");
    expect_at(c + 2, K_HEX, 64'(seg_456789ef), "hex_456789ef");
    expect_at(c + 3, K_HEX, 64'(seg_fedcba98), "hex_fedcba98");
    step(1);
    gpio_wdata = 32'hFEDCBA98;
    step(1);
    GPIO_we = 1'b0;
    step(3);

    // Clean switch change: accepted 6 edges later with a one-cycle pulse
    c = cyc;
    SW = 18'h2A5A5;
    expect_at(c + 5, K_IO0, 64'd0, "io0_before_accept");
    expect_at(c + 5, K_CHG, 64'd0, "chg_before_accept");
    expect_at(c + 6, K_IO0, 64'h0002A5A5, "io0_accept");
    expect_at(c + 6, K_CHG, 64'd1, "chg_pulse");
    expect_at(c + 7, K_CHG, 64'd0, "chg_one_cycle");
    step(8);
    c = cyc;
    SW = '0;
    expect_at(c + 5, K_IO0, 64'h0002A5A5, "io0_hold_before_clear");
    expect_at(c + 6, K_IO0, 64'd0, "io0_clear");
    expect_at(c + 6, K_CHG, 64'd1, "chg_clear_pulse");
    step(8);

    // Short bounce (2 cycles) must be rejected
    c = cyc;
    SW = 18'h1;
    for (int k = 1; k <= 10; k++) begin
      expect_at(c + k, K_IO0, 64'd0, "io0_bounce");
      expect_at(c + k, K_CHG, 64'd0, "chg_bounce");
    end
    step(2);
    SW = '0;
    step(10);

    // Reset mid-count discards the pending change
    c = cyc;
    SW = 18'h1;
    step(3);
    rst_n = 1'b0;
    expect_at(c + 4, K_IO0, 64'd0, "io0_midcount_reset");
    expect_at(c + 4, K_IO2, 64'd0, "io2_midcount_reset");
    expect_at(c + 4, K_HEX, 64'(seg_blank), "hex_midcount_reset");
    step(1);
    rst_n = 1'b1;
    m = cyc;
    expect_at(m + 1, K_HEX, 64'(seg_zero), "hex_zero_after_rerelease");
    expect_at(m + 5, K_IO0, 64'd0, "io0_after_reset_pending");
    expect_at(m + 6, K_IO0, 64'd1, "io0_after_reset_accept");
    expect_at(m + 6, K_CHG, 64'd1, "chg_after_reset_accept");
    step(8);

    // Reset overrides a simultaneous write
    c = cyc;
    GPIO_we = 1'b1; gpio_wdata = 32'hFFFFFFFF; rst_n = 1'b0;
    expect_at(c + 1, K_IO2, 64'd0, "io2_reset_beats_we");
    expect_at(c + 1, K_HEX, 64'(seg_blank), "hex_reset_beats_we");
    expect_at(c + 2, K_IO2, 64'd0, "io2_after_we_reset");
    expect_at(c + 2, K_HEX, 64'(seg_zero), "hex_after_we_reset");
    step(1);
    GPIO_we = 1'b0; rst_n = 1'b1;
    step(4);

    flush = 1'b1;
    for (int k = 0; k < 10 && !flushed; k++) @(posedge clk);
    if (!flushed) begin
      $display("FAIL flush_timeout: monitor did not drain");
      $fatal(1, "scoreboard flush timeout");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
